writeback_unit: RTL
===================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, the number of execution-unit result sources (bypass, logic, shift, adder).
REQ-002 SHALL have parameter DEPTH, default 2, the per-source buffer entries (power of two).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 flush  input  1  discard all buffered results (pipeline squash).
REQ-006 src_valid  input  NUM_SRC  source i presents a result this cycle.
REQ-007 src_rd  input  NUM_SRC x 5  destination register index per source.
REQ-008 src_result  input  NUM_SRC x 32  result_out value per source.
REQ-009 src_ready  output  NUM_SRC  source i may present; registered, from buffer occupancy.
REQ-010 rf_we  output  1  register-file write enable.
REQ-011 rf_addr  output  5  register-file write index.
REQ-012 rf_data  output  32  register-file write data.
REQ-013 busy  output  1  any buffer non-empty.

Function
REQ-014 Source i transfer SHALL occur when src_valid[i] and src_ready[i] are both high on a rising edge; src_valid while src_ready low is ignored (no transfer, no error).
REQ-015 Transfer with src_rd = 0 SHALL complete the handshake but not be stored (x0 discard).
REQ-016 Each source SHALL own a FIFO of DEPTH entries {rd, result}; src_ready[i] = (count_i < DEPTH), computed from registered count only.
REQ-017 Each cycle, arbiter SHALL grant one non-empty FIFO by round-robin starting from priority pointer ptr; granted head is popped.
REQ-018 After grant to source g, ptr SHALL become (g+1) mod NUM_SRC; no grant leaves ptr unchanged.
REQ-019 Write port SHALL be registered: grant in cycle N drives rf_we=1, rf_addr, rf_data during cycle N+1; no grant drives rf_we=0 (rf_addr/rf_data hold last value).
REQ-020 Minimum latency, transfer edge to rf_we high, SHALL be 2 cycles (enqueue edge, grant cycle, output register edge).
REQ-021 Per-source order SHALL be preserved; no ordering guaranteed across sources.
REQ-022 Simultaneous push and pop on the same FIFO SHALL both take effect; count unchanged.
REQ-023 FIFO read/write pointers SHALL wrap modulo DEPTH; count range 0..DEPTH.
REQ-024 flush SHALL, on the edge it is sampled, empty all FIFOs, set rf_we=0 next cycle, and ignore same-cycle pushes and grants; ptr unchanged.
REQ-025 busy SHALL equal OR of (count_i != 0), registered-state derived.
REQ-026 Sustained throughput SHALL be one register write per cycle while any FIFO is non-empty.

Reset
REQ-027 With reset low at a rising edge: all counts and FIFO pointers 0, ptr 0, rf_we 0, rf_addr 0, rf_data 0; src_ready all 1 and busy 0 in the following cycle.
REQ-028 Reset mid-operation SHALL drop all buffered results without issuing any write; reset takes priority over flush and transfers.

Structure
REQ-029 NUM_SRC, DEPTH defaults, source index enum (SRC_BYPASS, SRC_LOGIC, SRC_SHIFT, SRC_ADDER) and packed struct wb_entry_t {rd[4:0], data[31:0]} SHALL live in my_pkg.
REQ-030 Per-source buffer SHALL be a sub-module wb_fifo (DEPTH entries, push/pop/count/flush), instantiated NUM_SRC times.
REQ-031 Round-robin arbiter and output register SHALL be in writeback_unit itself.

Verification
REQ-032 Single transfer: src 0 valid, rd=5, result=0xDEADBEEF -> rf_we=1, rf_addr=5, rf_data=0xDEADBEEF exactly 2 cycles later, busy returns 0.
REQ-033 All four sources valid same cycle, rd=1..4, data=0x11..0x44 -> writes on 4 consecutive cycles in order rd 1,2,3,4; next simultaneous burst starts from ptr=0 again.
REQ-034 Source 2 pushes 3 results back-to-back while sources 0,1 continuously busy -> src_ready[2] low after 2 accepted, third held until ready, all three written in push order.
REQ-035 Transfer with rd=0, data=0xFFFFFFFF -> handshake completes, no rf_we pulse, busy stays 0.
REQ-036 Fill sources 0 and 3 (2 entries each), assert flush one cycle -> no further rf_we, busy 0 and src_ready all 1 next cycle.
REQ-037 Reset low for one edge while 3 entries buffered -> all outputs zero, no write issued afterwards, src_ready all 1.

Source files
------------

// File: rtl/my_pkg.sv
// rtl/my_pkg.sv - shared defaults and types for the writeback unit
// Purpose: default sizing, source index names and the buffered entry layout
// used by writeback_unit and wb_fifo. No ports.
package my_pkg;

   localparam int NUM_SRC_DEF = 4;
   localparam int DEPTH_DEF   = 2;

   typedef enum logic [1:0] {
      SRC_BYPASS = 2'd0,
      SRC_LOGIC  = 2'd1,
      SRC_SHIFT  = 2'd2,
      SRC_ADDER  = 2'd3
   } src_idx_t;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - per-source result buffer for the writeback unit
// Purpose: DEPTH-entry FIFO of {rd, data} results.
// Ports:
//   clk, reset (sync, active-low)  - clock and reset
//   flush                          - empty the buffer; same-cycle push/pop ignored
//   push, push_entry               - enqueue (caller guarantees count < DEPTH)
//   pop                            - dequeue head (caller guarantees count > 0)
//   head_entry                     - oldest buffered entry
//   count                          - registered occupancy, 0..DEPTH
module wb_fifo
   import my_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           flush,
   input  logic                           push,
   input  wb_entry_t                      push_entry,
   input  logic                           pop,
   output wb_entry_t                      head_entry,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   wb_entry_t     mem_q [DEPTH];
   wb_entry_t     mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wrap_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = wrap_inc(rd_ptr_q);
         end
         // push and pop together leave the occupancy unchanged
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head_entry = mem_q[rd_ptr_q];
   assign count      = count_q;

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - buffered round-robin register-file writeback
// Purpose: collects results from NUM_SRC execution units into per-source
// FIFOs and retires one per cycle to the register file.
// Ports:
//   clk, reset (sync, active-low), flush (squash all buffered results)
//   src_valid/src_rd/src_result - per-source result offer
//   src_ready                   - per-source accept, from registered occupancy
//   rf_we/rf_addr/rf_data       - registered register-file write port
//   busy                        - some buffer holds a result
module writeback_unit
   import my_pkg::*;
#(
   parameter int NUM_SRC = NUM_SRC_DEF,
   parameter int DEPTH   = DEPTH_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic [NUM_SRC-1:0]        src_valid,
   input  logic [NUM_SRC-1:0][4:0]   src_rd,
   input  logic [NUM_SRC-1:0][31:0]  src_result,
   output logic [NUM_SRC-1:0]        src_ready,
   output logic                      rf_we,
   output logic [4:0]                rf_addr,
   output logic [31:0]               rf_data,
   output logic                      busy
);

   localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [CW-1:0]      count [NUM_SRC];
   wb_entry_t          head  [NUM_SRC];
   logic [NUM_SRC-1:0] push;
   logic [NUM_SRC-1:0] pop;

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] grant_idx, arb_cand;
   logic          grant_found, grant;

   logic          rf_we_q, rf_we_d;
   logic [4:0]    rf_addr_q, rf_addr_d;
   logic [31:0]   rf_data_q, rf_data_d;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      wb_entry_t push_entry;

      assign src_ready[i] = (count[i] < CW'(DEPTH));
      // x0 results complete the handshake but are never buffered
      assign push[i]      = src_valid[i] & src_ready[i] & (src_rd[i] != 5'd0);
      assign push_entry   = '{rd: src_rd[i], data: src_result[i]};

      wb_fifo #(.DEPTH(DEPTH)) u_fifo (
         .clk        (clk),
         .reset      (reset),
         .flush      (flush),
         .push       (push[i]),
         .push_entry (push_entry),
         .pop        (pop[i]),
         .head_entry (head[i]),
         .count      (count[i])
      );
   end

   // Search starts at ptr and wraps; first non-empty FIFO wins.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      arb_cand    = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         arb_cand = PW'((int'(ptr_q) + k) % NUM_SRC);
         if (!grant_found && (count[arb_cand] != '0)) begin
            grant_found = 1'b1;
            grant_idx   = arb_cand;
         end
      end
   end

   assign grant = grant_found & ~flush;

   always_comb begin
      pop = '0;
      if (grant) begin
         pop[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      ptr_d     = ptr_q;
      rf_we_d   = grant;
      rf_addr_d = rf_addr_q;
      rf_data_d = rf_data_q;
      if (grant) begin
         ptr_d     = (grant_idx == PW'(NUM_SRC - 1)) ? '0 : grant_idx + PW'(1);
         rf_addr_d = head[grant_idx].rd;
         rf_data_d = head[grant_idx].data;
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         busy = busy | (count[k] != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr_q     <= '0;
         rf_we_q   <= 1'b0;
         rf_addr_q <= '0;
         rf_data_q <= '0;
      end else begin
         ptr_q     <= ptr_d;
         rf_we_q   <= rf_we_d;
         rf_addr_q <= rf_addr_d;
         rf_data_q <= rf_data_d;
      end
   end

   assign rf_we   = rf_we_q;
   assign rf_addr = rf_addr_q;
   assign rf_data = rf_data_q;

endmodule
